// File: rtl/fft_bin_pkg.sv
// Shared defaults, frame length and FSM state type for the FFT bin collector.
package fft_bin_pkg;

  localparam int unsigned DATA_W_DEF = 14;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned FFT_LEN    = 2 ** ADDR_W_DEF;

  typedef enum logic {
    CAPTURE = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/fft_mag_abs.sv
// Registered |re| + |im| magnitude estimate, one bit wider than the inputs so
// the most negative input (and the sum of two of them) never wraps.
module fft_mag_abs
  import fft_bin_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     sclk,
  input  logic                     s_rst_n,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_re,
  input  logic signed [DATA_W-1:0] i_im,
  output logic        [DATA_W:0]   o_mag
);

  logic [DATA_W:0] w_re_ext;
  logic [DATA_W:0] w_im_ext;
  logic [DATA_W:0] w_re_abs;
  logic [DATA_W:0] w_im_abs;
  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] r_mag;

  // Sign-extend first so negating -2**(DATA_W-1) yields +2**(DATA_W-1).
  assign w_re_ext = {i_re[DATA_W-1], i_re};
  assign w_im_ext = {i_im[DATA_W-1], i_im};
  assign w_re_abs = i_re[DATA_W-1] ? (~w_re_ext + (DATA_W+1)'(1)) : w_re_ext;
  assign w_im_abs = i_im[DATA_W-1] ? (~w_im_ext + (DATA_W+1)'(1)) : w_im_ext;
  assign w_sum    = w_re_abs + w_im_abs;

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_mag <= '0;
    end else if (i_en) begin
      r_mag <= w_sum;
    end
  end

  assign o_mag = r_mag;

endmodule

// File: rtl/fft_bin_collector.sv
// Collects one FFT frame of |re|+|im| magnitudes into a RAM, holds it for readout,
// and flags short/long frames. Optional peak tracking under macro PEAK_TRACK_EN.
module fft_bin_collector
  import fft_bin_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     sclk,
  input  logic                     s_rst_n,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     in_ready,
  input  logic                     rd_en,
  input  logic        [ADDR_W-1:0] rd_addr,
  output logic        [DATA_W:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     frame_release,
  output logic                     frame_done,
  output logic                     err_short,
  output logic                     err_long
`ifdef PEAK_TRACK_EN
  ,
  output logic        [ADDR_W-1:0] peak_bin,
  output logic        [DATA_W:0]   peak_mag
`endif
);

  localparam int unsigned MAG_W = DATA_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_bin_cnt;
  logic [ADDR_W-1:0]  w_bin_cnt_nxt;
  logic               r_ready;
  logic               w_accept;
  logic               w_s1_last;
  logic               w_s1_long;
  logic               w_s1_short;

  logic               r_s1_vld;
  logic               r_s1_last;
  logic               r_s1_long;
  logic               r_s1_short;
  logic [ADDR_W-1:0]  r_s1_addr;
  logic [MAG_W-1:0]   w_mag;

  logic [MAG_W-1:0]   r_ram [DEPTH];
  logic [MAG_W-1:0]   r_rd_data;
  logic               r_rd_valid;
  logic               r_frame_done;
  logic               r_err_short;
  logic               r_err_long;

  assign w_accept = in_valid & r_ready;

  // Next state and bin counter; the final bin index is all-ones in bin_cnt.
  always_comb begin
    w_state_nxt   = r_state;
    w_bin_cnt_nxt = r_bin_cnt;
    w_s1_last     = 1'b0;
    w_s1_long     = 1'b0;
    w_s1_short    = 1'b0;
    case (r_state)
      CAPTURE: begin
        if (w_accept) begin
          if (&r_bin_cnt) begin
            w_state_nxt   = HOLD;
            w_bin_cnt_nxt = '0;
            w_s1_last     = 1'b1;
            w_s1_long     = ~in_last;
          end else if (in_last) begin
            w_bin_cnt_nxt = '0;
            w_s1_short    = 1'b1;
          end else begin
            w_bin_cnt_nxt = r_bin_cnt + ADDR_W'(1);
          end
        end
      end
      HOLD: begin
        if (frame_release) begin
          w_state_nxt   = CAPTURE;
          w_bin_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = CAPTURE;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_state   <= CAPTURE;
      r_bin_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin_cnt <= w_bin_cnt_nxt;
      r_ready   <= (w_state_nxt == CAPTURE);
    end
  end

  // Bin tags travel alongside the magnitude register so the write and pulses line up.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_long  <= 1'b0;
      r_s1_short <= 1'b0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_vld   <= w_accept;
      r_s1_last  <= w_s1_last;
      r_s1_long  <= w_s1_long;
      r_s1_short <= w_s1_short;
      r_s1_addr  <= r_bin_cnt;
    end
  end

  fft_mag_abs #(
    .DATA_W (DATA_W)
  ) u_mag (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .i_en    (w_accept),
    .i_re    (in_re),
    .i_im    (in_im),
    .o_mag   (w_mag)
  );

  // A short-frame terminating bin is dropped; the next frame restarts at address 0.
  always_ff @(posedge sclk) begin
    if (r_s1_vld && !r_s1_short) begin
      r_ram[r_s1_addr] <= w_mag;
    end
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en && (r_state == HOLD);
      if (rd_en && (r_state == HOLD)) begin
        r_rd_data <= r_ram[rd_addr];
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
    end else begin
      r_frame_done <= r_s1_vld & r_s1_last;
      r_err_short  <= r_s1_vld & r_s1_short;
      r_err_long   <= r_s1_vld & r_s1_long;
    end
  end

  assign in_ready   = r_ready;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign frame_done = r_frame_done;
  assign err_short  = r_err_short;
  assign err_long   = r_err_long;

`ifdef PEAK_TRACK_EN
  logic [MAG_W-1:0]  r_run_mag;
  logic [MAG_W-1:0]  w_run_mag_nxt;
  logic [ADDR_W-1:0] r_run_bin;
  logic [ADDR_W-1:0] w_run_bin_nxt;
  logic [MAG_W-1:0]  r_peak_mag;
  logic [ADDR_W-1:0] r_peak_bin;

  // Bin 0 restarts the running peak; strict compare keeps the lowest bin on ties.
  always_comb begin
    w_run_mag_nxt = r_run_mag;
    w_run_bin_nxt = r_run_bin;
    if (r_s1_vld && !r_s1_short) begin
      if ((r_s1_addr == '0) || (w_mag > r_run_mag)) begin
        w_run_mag_nxt = w_mag;
        w_run_bin_nxt = r_s1_addr;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_run_mag  <= '0;
      r_run_bin  <= '0;
      r_peak_mag <= '0;
      r_peak_bin <= '0;
    end else begin
      r_run_mag <= w_run_mag_nxt;
      r_run_bin <= w_run_bin_nxt;
      if (r_s1_vld && r_s1_last) begin
        r_peak_mag <= w_run_mag_nxt;
        r_peak_bin <= w_run_bin_nxt;
      end
    end
  end

  assign peak_bin = r_peak_bin;
  assign peak_mag = r_peak_mag;
`endif

endmodule

// File: tb/tb_fft_bin_collector.sv
// Directed self-checking bench for fft_bin_collector (peak checks only when PEAK_TRACK_EN is defined).
module tb_fft_bin_collector;
  import fft_bin_pkg::*;

  localparam int unsigned DW = 14;
  localparam int unsigned AW = 10;

  logic                 sclk = 1'b0;
  logic                 s_rst_n;
  logic                 in_valid;
  logic                 in_last;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 in_ready;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [DW:0]          rd_data;
  logic                 rd_valid;
  logic                 frame_release;
  logic                 frame_done;
  logic                 err_short;
  logic                 err_long;
`ifdef PEAK_TRACK_EN
  logic [AW-1:0]        peak_bin;
  logic [DW:0]          peak_mag;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_done = 0;
  int cnt_short = 0;
  int cnt_long = 0;
  int cnt_both = 0;

  fft_bin_collector #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .sclk          (sclk),
    .s_rst_n       (s_rst_n),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_re         (in_re),
    .in_im         (in_im),
    .in_ready      (in_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .frame_release (frame_release),
    .frame_done    (frame_done),
    .err_short     (err_short),
    .err_long      (err_long)
`ifdef PEAK_TRACK_EN
    ,
    .peak_bin      (peak_bin),
    .peak_mag      (peak_mag)
`endif
  );

  always #5 sclk = ~sclk;

  // Pulse counters sampled mid-cycle.
  always @(negedge sclk) begin
    if (frame_done === 1'b1) cnt_done <= cnt_done + 1;
    if (err_short === 1'b1) cnt_short <= cnt_short + 1;
    if (err_long === 1'b1) cnt_long <= cnt_long + 1;
    if (frame_done === 1'b1 && err_long === 1'b1) cnt_both <= cnt_both + 1;
  end

  function automatic int val_re(input int mode, input int i);
    case (mode)
      0: return i;
      1: return (i == 17 || i == 300) ? 5000 : (i % 16);
      default: return (i == 0) ? -8192 : 1;
    endcase
  endfunction

  function automatic int val_im(input int mode, input int i);
    case (mode)
      0: return -i;
      1: return (i == 17 || i == 300) ? -3000 : -(i % 8);
      default: return (i == 0) ? -8192 : 0;
    endcase
  endfunction

  task automatic send_bins(input int mode, input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      in_valid = 1'b1;
      in_last  = (i == last_idx);
      in_re    = DW'(val_re(mode, i));
      in_im    = DW'(val_im(mode, i));
    end
    @(negedge sclk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rd(input int addr, input logic rel, output logic [DW:0] data,
                    output logic v1, output logic v2);
    @(negedge sclk);
    rd_en = 1'b1;
    rd_addr = AW'(addr);
    frame_release = rel;
    @(negedge sclk);
    rd_en = 1'b0;
    frame_release = 1'b0;
    v1 = rd_valid;
    data = rd_data;
    @(negedge sclk);
    v2 = rd_valid;
  endtask

  task automatic do_release();
    @(negedge sclk);
    frame_release = 1'b1;
    @(negedge sclk);
    frame_release = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW:0] d;
    logic v1, v2;
    repeat (3) @(negedge sclk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if ({rd_valid, frame_done, err_short, err_long} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {rd_valid, frame_done, err_short, err_long}); else n_pass++;
    n_checks++; if (rd_data !== 15'd0) $display("FAIL reset_rd_data: got %0d expected 0", rd_data); else n_pass++;
`ifdef PEAK_TRACK_EN
    n_checks++; if ({peak_bin, peak_mag} !== 25'd0) $display("FAIL reset_peak: got %0d/%0d expected 0/0", peak_bin, peak_mag); else n_pass++;
`endif
    s_rst_n = 1'b1;
    @(negedge sclk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", in_ready); else n_pass++;
    rd(5, 1'b0, d, v1, v2);
    n_checks++; if (v1 !== 1'b0) $display("FAIL rd_in_capture: got rd_valid=%b expected 0", v1); else n_pass++;
  endtask

  task automatic test_ramp();
    logic [DW:0] d;
    logic v1, v2;
    int b, es, el;
    b = cnt_done; es = cnt_short; el = cnt_long;
    send_bins(0, 1024, 1023);
    repeat (8) @(negedge sclk);
    n_checks++; if (cnt_done - b != 1) $display("FAIL ramp_done_count: got %0d expected 1", cnt_done - b); else n_pass++;
    n_checks++; if ((cnt_short - es) + (cnt_long - el) != 0) $display("FAIL ramp_no_err: got %0d expected 0", (cnt_short - es) + (cnt_long - el)); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL ramp_hold_ready: got %b expected 0", in_ready); else n_pass++;
    rd(5, 1'b0, d, v1, v2);
    n_checks++; if (v1 !== 1'b1 || v2 !== 1'b0) $display("FAIL ramp_rd_valid: got %b%b expected 10", v1, v2); else n_pass++;
    n_checks++; if (d !== 15'd10) $display("FAIL ramp_ram5: got %0d expected 10", d); else n_pass++;
    rd(1023, 1'b0, d, v1, v2);
    n_checks++; if (d !== 15'd2046 || v1 !== 1'b1) $display("FAIL ramp_ram1023: got %0d valid %b expected 2046 valid 1", d, v1); else n_pass++;
`ifdef PEAK_TRACK_EN
    n_checks++; if (peak_bin !== 10'd1023 || peak_mag !== 15'd2046) $display("FAIL ramp_peak: got %0d/%0d expected 1023/2046", peak_bin, peak_mag); else n_pass++;
`endif
    do_release();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL ramp_release: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_short_then_min();
    logic [DW:0] d;
    logic v1, v2;
    int b, es;
    b = cnt_done; es = cnt_short;
    send_bins(0, 100, 99);
    repeat (4) @(negedge sclk);
    n_checks++; if (cnt_short - es != 1) $display("FAIL short_err: got %0d expected 1", cnt_short - es); else n_pass++;
    n_checks++; if (cnt_done - b != 0) $display("FAIL short_no_done: got %0d expected 0", cnt_done - b); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL short_stays_capture: got %b expected 1", in_ready); else n_pass++;
    b = cnt_done;
    send_bins(2, 1024, 1023);
    repeat (8) @(negedge sclk);
    n_checks++; if (cnt_done - b != 1) $display("FAIL min_done_count: got %0d expected 1", cnt_done - b); else n_pass++;
    rd(0, 1'b0, d, v1, v2);
    n_checks++; if (d !== 15'd16384 || v1 !== 1'b1) $display("FAIL min_mag_addr0: got %0d valid %b expected 16384 valid 1", d, v1); else n_pass++;
    rd(99, 1'b0, d, v1, v2);
    n_checks++; if (d !== 15'd1) $display("FAIL min_ram99: got %0d expected 1", d); else n_pass++;
`ifdef PEAK_TRACK_EN
    n_checks++; if (peak_bin !== 10'd0 || peak_mag !== 15'd16384) $display("FAIL min_peak: got %0d/%0d expected 0/16384", peak_bin, peak_mag); else n_pass++;
`endif
    do_release();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL min_release: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_long();
    logic [DW:0] d;
    logic v1, v2;
    int bb, el;
    bb = cnt_both; el = cnt_long;
    send_bins(0, 1024, -1);
    repeat (8) @(negedge sclk);
    n_checks++; if (cnt_long - el != 1) $display("FAIL long_err: got %0d expected 1", cnt_long - el); else n_pass++;
    n_checks++; if (cnt_both - bb != 1) $display("FAIL long_with_done: got %0d expected 1", cnt_both - bb); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL long_hold: got %b expected 0", in_ready); else n_pass++;
    rd(1023, 1'b0, d, v1, v2);
    n_checks++; if (d !== 15'd2046 || v1 !== 1'b1) $display("FAIL long_ram1023: got %0d valid %b expected 2046 valid 1", d, v1); else n_pass++;
    do_release();
  endtask

  task automatic test_peak_hold();
    logic [DW:0] d;
    logic v1, v2;
    int b;
    b = cnt_done;
    send_bins(1, 1024, 1023);
    repeat (8) @(negedge sclk);
    n_checks++; if (cnt_done - b != 1) $display("FAIL peak_done: got %0d expected 1", cnt_done - b); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL peak_hold_ready: got %b expected 0", in_ready); else n_pass++;
    rd(17, 1'b0, d, v1, v2);
    n_checks++; if (v1 !== 1'b1 || v2 !== 1'b0 || d !== 15'd8000)
      $display("FAIL peak_rd17: got %0d valid %b%b expected 8000 valid 10", d, v1, v2); else n_pass++;
`ifdef PEAK_TRACK_EN
    n_checks++; if (peak_bin !== 10'd17 || peak_mag !== 15'd8000) $display("FAIL peak_tie: got %0d/%0d expected 17/8000", peak_bin, peak_mag); else n_pass++;
`endif
    rd(300, 1'b1, d, v1, v2);
    n_checks++; if (v1 !== 1'b1 || d !== 15'd8000) $display("FAIL rd_with_release: got %0d valid %b expected 8000 valid 1", d, v1); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", in_ready); else n_pass++;
    do_release();
    rd(5, 1'b0, d, v1, v2);
    n_checks++; if (v1 !== 1'b0 || in_ready !== 1'b1) $display("FAIL capture_rd_ignored: got valid %b ready %b expected 0 1", v1, in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [DW:0] d;
    logic v1, v2;
    int b, el;
    send_bins(0, 500, -1);
    @(negedge sclk);
    s_rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_reset_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if ({rd_valid, frame_done, err_short, err_long} !== 4'b0000 || rd_data !== 15'd0)
      $display("FAIL mid_reset_outputs: got flags %b data %0d expected 0000 0", {rd_valid, frame_done, err_short, err_long}, rd_data); else n_pass++;
`ifdef PEAK_TRACK_EN
    n_checks++; if ({peak_bin, peak_mag} !== 25'd0) $display("FAIL mid_reset_peak: got %0d/%0d expected 0/0", peak_bin, peak_mag); else n_pass++;
`endif
    s_rst_n = 1'b1;
    @(negedge sclk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_ready_after: got %b expected 1", in_ready); else n_pass++;
    b = cnt_done; el = cnt_long;
    send_bins(1, 1024, 1023);
    repeat (8) @(negedge sclk);
    n_checks++; if (cnt_done - b != 1 || cnt_long - el != 0)
      $display("FAIL mid_next_frame: got done %0d long %0d expected 1 0", cnt_done - b, cnt_long - el); else n_pass++;
    rd(5, 1'b0, d, v1, v2);
    n_checks++; if (d !== 15'd10 || v1 !== 1'b1) $display("FAIL mid_ram5: got %0d valid %b expected 10 valid 1", d, v1); else n_pass++;
    rd(0, 1'b0, d, v1, v2);
    n_checks++; if (d !== 15'd0) $display("FAIL mid_ram0: got %0d expected 0", d); else n_pass++;
`ifdef PEAK_TRACK_EN
    n_checks++; if (peak_bin !== 10'd17) $display("FAIL mid_peak: got %0d expected 17", peak_bin); else n_pass++;
`endif
  endtask

  initial begin
    s_rst_n       = 1'b0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_re         = '0;
    in_im         = '0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    frame_release = 1'b0;
    test_reset();
    test_ramp();
    test_short_then_min();
    test_long();
    test_peak_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
